melody_sequencer: RTL

//  Plays a fixed tune from an internal song ROM by driving tone/tone_en into the beeper tone generator.

---
 rtl/melody_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Purpose : plays a fixed 16-entry song ROM as tone codes + beeper enable, with play/pause/stop and optional looping.
// Latency : play sampled in cycle t -> FETCH at t+1 -> tone/tone_en valid from t+2; per-note period beats*BEAT_CYCLES+1.
// Backpr. : none; pause freezes note/gap timing and mutes tone_en, stop aborts to IDLE with top priority.
// Ports   : clk_in, rst_n_in (async active-low); play/pause/stop requests in;
//           tone[4:0], tone_en, note_idx[3:0] registered out; busy (not IDLE), done (1-cycle end-of-song pulse).
module melody_sequencer #(
  parameter int BEAT_CYCLES = 3_000_000,
  parameter int GAP_CYCLES  = 240_000,
  parameter bit LOOP        = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       play,
  input  logic       pause,
  input  logic       stop,
  output logic [4:0] tone,
  output logic       tone_en,
  output logic [3:0] note_idx,
  output logic       busy,
  output logic       done
);

  localparam int CW = 26;
  localparam logic [CW-1:0] BEAT_W   = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0] GAP_W    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_NOTE,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    tone_nxt;
  logic          tone_en_nxt;
  logic [3:0]    idx_nxt;

  logic [7:0]    rom_dat;
  logic [4:0]    rom_tone;
  logic [2:0]    rom_beats;
  logic [CW-1:0] note_load;

  // Song ROM: {tone[4:0], beats[2:0]}; beats == 0 marks the end of the song.
  always_comb begin
    rom_dat = 8'h00;
    case (note_idx)
      4'd0:    rom_dat = {5'h01, 3'd1};
      4'd1:    rom_dat = {5'h02, 3'd1};
      4'd2:    rom_dat = {5'h03, 3'd1};
      4'd3:    rom_dat = {5'h00, 3'd1};
      4'd4:    rom_dat = {5'h05, 3'd2};
      4'd5:    rom_dat = {5'h06, 3'd1};
      4'd6:    rom_dat = {5'h11, 3'd2};
      4'd7:    rom_dat = {5'h15, 3'd4};
      default: rom_dat = 8'h00;
    endcase
  end

  assign rom_tone  = rom_dat[7:3];
  assign rom_beats = rom_dat[2:0];

  // NOTE counts down from load to 0 inclusive, so it lasts beats*BEAT-GAP cycles.
  assign note_load = CW'(rom_beats) * BEAT_W - GAP_W - CW'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tone_nxt    = tone;
    tone_en_nxt = 1'b0;
    idx_nxt     = note_idx;

    if (stop) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      tone_nxt  = 5'h00;
      idx_nxt   = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (play) begin
            state_nxt = S_FETCH;
            idx_nxt   = 4'd0;
          end
        end
        S_FETCH: begin
          if (rom_beats == 3'd0) begin
            state_nxt = S_DONE;
            tone_nxt  = 5'h00;
          end else begin
            state_nxt   = S_NOTE;
            tone_nxt    = rom_tone;
            tone_en_nxt = (rom_tone != 5'h00);
            cnt_nxt     = note_load;
          end
        end
        S_NOTE: begin
          // Paused: counter holds and tone_en stays at its default of 0.
          if (!pause) begin
            if (cnt == '0) begin
              state_nxt = S_GAP;
              cnt_nxt   = GAP_LAST;
            end else begin
              cnt_nxt     = cnt - CW'(1);
              tone_en_nxt = (tone != 5'h00);
            end
          end
        end
        S_GAP: begin
          if (!pause) begin
            if (cnt == '0) begin
              state_nxt = S_FETCH;
              idx_nxt   = note_idx + 4'd1;
            end else begin
              cnt_nxt = cnt - CW'(1);
            end
          end
        end
        S_DONE: begin
          idx_nxt   = 4'd0;
          state_nxt = LOOP ? S_FETCH : S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          tone_nxt  = 5'h00;
          idx_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tone     <= 5'h00;
      tone_en  <= 1'b0;
      note_idx <= 4'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tone     <= tone_nxt;
      tone_en  <= tone_en_nxt;
      note_idx <= idx_nxt;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
